// File: rtl/lsu_mem_if.sv
// lsu_mem_if: load/store unit for the milano EX stage.
//   Accepts one LSU command at a time from the ID-EX register, runs the
//   data-memory req/gnt/rvalid handshake, aligns store lanes and byte
//   enables, extracts/extends load data and drives the register-file
//   write port for loads.
// Ports:
//   clk_i, rst_ni                        clock, async active-low reset
//   lsu_req_i/we_i/operate_i/addr_i/wdata_i, rd_addr_i   command in
//   lsu_busy_o, lsu_err_o                status to the pipeline
//   data_req_o/gnt_i/rvalid_i/err_i/addr_o/we_o/be_o/wdata_o/rdata_i
//                                        data-memory interface
//   we_o, waddr_o, wdata_o               register-file write port
package milano_pkg;
  typedef enum logic [2:0] {
    LSU_LB, LSU_LH, LSU_LW, LSU_LBU, LSU_LHU, LSU_SB, LSU_SH, LSU_SW
  } lsu_opt_e;
endpackage

module lsu_mem_if #(
  parameter int ADDR_W         = 32,
  parameter bit MISALIGN_CHECK = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 lsu_req_i,
  input  logic                 lsu_we_i,
  input  milano_pkg::lsu_opt_e lsu_operate_i,
  input  logic [31:0]          lsu_addr_i,
  input  logic [31:0]          lsu_wdata_i,
  input  logic [4:0]           rd_addr_i,
  output logic                 lsu_busy_o,
  output logic                 lsu_err_o,
  output logic                 data_req_o,
  input  logic                 data_gnt_i,
  input  logic                 data_rvalid_i,
  input  logic                 data_err_i,
  output logic [ADDR_W-1:0]    data_addr_o,
  output logic                 data_we_o,
  output logic [3:0]           data_be_o,
  output logic [31:0]          data_wdata_o,
  input  logic [31:0]          data_rdata_i,
  output logic                 we_o,
  output logic [4:0]           waddr_o,
  output logic [31:0]          wdata_o
);
  import milano_pkg::*;

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP} state_e;

  function automatic logic [3:0] store_be(input lsu_opt_e op, input logic [1:0] off);
    case (op)
      LSU_SB:  return 4'b0001 << off;
      LSU_SH:  return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input lsu_opt_e op, input logic [31:0] d);
    case (op)
      LSU_SB:  return {4{d[7:0]}};
      LSU_SH:  return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] load_data(input lsu_opt_e op, input logic [1:0] off,
                                            input logic [31:0] rdata);
    logic        [31:0] shifted;
    logic signed [7:0]  sb;
    logic signed [15:0] sh;
    shifted = rdata >> {off, 3'b000};
    sb      = shifted[7:0];
    sh      = shifted[15:0];
    case (op)
      LSU_LB:  return 32'(sb);
      LSU_LH:  return 32'(sh);
      LSU_LBU: return {24'h0, shifted[7:0]};
      LSU_LHU: return {16'h0, shifted[15:0]};
      default: return rdata;
    endcase
  endfunction

  state_e            state_q, state_d;
  lsu_opt_e          op_q, op_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       dwdata_q, dwdata_d;
  logic [4:0]        rd_q, rd_d;
  logic              err_q, err_d;
  logic              wb_we_q, wb_we_d;
  logic [4:0]        wb_waddr_q, wb_waddr_d;
  logic [31:0]       wb_wdata_q, wb_wdata_d;

  logic              is_half, is_word, misaligned;
  logic [ADDR_W-1:0] acc_addr;

  always_comb begin
    is_half    = (lsu_operate_i == LSU_LH) || (lsu_operate_i == LSU_LHU) ||
                 (lsu_operate_i == LSU_SH);
    is_word    = (lsu_operate_i == LSU_LW) || (lsu_operate_i == LSU_SW);
    misaligned = (is_half && lsu_addr_i[0]) || (is_word && (lsu_addr_i[1:0] != 2'b00));
    // With checking disabled, the offending low bits are cleared so the access
    // falls back to the naturally aligned lane.
    acc_addr   = lsu_addr_i[ADDR_W-1:0];
    if (is_half) acc_addr[0]   = 1'b0;
    if (is_word) acc_addr[1:0] = 2'b00;
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    we_d       = we_q;
    addr_d     = addr_q;
    be_d       = be_q;
    dwdata_d   = dwdata_q;
    rd_d       = rd_q;
    err_d      = 1'b0;
    wb_we_d    = 1'b0;
    wb_waddr_d = wb_waddr_q;
    wb_wdata_d = wb_wdata_q;
    case (state_q)
      IDLE: begin
        if (lsu_req_i) begin
          op_d     = lsu_operate_i;
          we_d     = lsu_we_i;
          addr_d   = acc_addr;
          rd_d     = rd_addr_i;
          be_d     = lsu_we_i ? store_be(lsu_operate_i, acc_addr[1:0]) : 4'b1111;
          dwdata_d = store_data(lsu_operate_i, lsu_wdata_i);
          if (MISALIGN_CHECK && misaligned) err_d = 1'b1;
          else                              state_d = REQ;
        end
      end
      REQ: begin
        if (data_gnt_i) state_d = WAIT_RSP;
      end
      WAIT_RSP: begin
        if (data_rvalid_i) begin
          state_d = IDLE;
          if (data_err_i) begin
            err_d = 1'b1;
          end else if (!we_q && (rd_q != 5'd0)) begin
            wb_we_d    = 1'b1;
            wb_waddr_d = rd_q;
            wb_wdata_d = load_data(op_q, addr_q[1:0], data_rdata_i);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      op_q       <= LSU_LB;
      we_q       <= 1'b0;
      addr_q     <= '0;
      be_q       <= 4'b0000;
      dwdata_q   <= 32'h0;
      rd_q       <= 5'd0;
      err_q      <= 1'b0;
      wb_we_q    <= 1'b0;
      wb_waddr_q <= 5'd0;
      wb_wdata_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      dwdata_q   <= dwdata_d;
      rd_q       <= rd_d;
      err_q      <= err_d;
      wb_we_q    <= wb_we_d;
      wb_waddr_q <= wb_waddr_d;
      wb_wdata_q <= wb_wdata_d;
    end
  end

  always_comb begin
    lsu_busy_o   = (state_q != IDLE);
    lsu_err_o    = err_q;
    data_req_o   = (state_q == REQ);
    data_addr_o  = {addr_q[ADDR_W-1:2], 2'b00};
    data_we_o    = we_q;
    data_be_o    = be_q;
    data_wdata_o = dwdata_q;
    we_o         = wb_we_q;
    waddr_o      = wb_waddr_q;
    wdata_o      = wb_wdata_q;
  end

endmodule

// File: tb/tb_lsu_mem_if.sv
// Bench for lsu_mem_if: table of accesses driven back to back, with the
// register-file/error responses tracked through a queue, plus a reset-abort
// sequence.
module tb_lsu_mem_if;
  import milano_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        lsu_req, lsu_we;
  lsu_opt_e    lsu_op;
  logic [31:0] lsu_addr, lsu_wdata;
  logic [4:0]  rd_addr;
  logic        lsu_busy, lsu_err;
  logic        data_req, data_gnt, data_rvalid, data_err;
  logic [31:0] data_addr;
  logic        data_we;
  logic [3:0]  data_be;
  logic [31:0] data_wdata, data_rdata;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;

  always #5 clk = ~clk;

  lsu_mem_if #(.ADDR_W(32), .MISALIGN_CHECK(1'b1)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .lsu_req_i(lsu_req), .lsu_we_i(lsu_we), .lsu_operate_i(lsu_op),
    .lsu_addr_i(lsu_addr), .lsu_wdata_i(lsu_wdata), .rd_addr_i(rd_addr),
    .lsu_busy_o(lsu_busy), .lsu_err_o(lsu_err),
    .data_req_o(data_req), .data_gnt_i(data_gnt), .data_rvalid_i(data_rvalid),
    .data_err_i(data_err), .data_addr_o(data_addr), .data_we_o(data_we),
    .data_be_o(data_be), .data_wdata_o(data_wdata), .data_rdata_i(data_rdata),
    .we_o(we), .waddr_o(waddr), .wdata_o(wdata)
  );

  typedef struct {
    lsu_opt_e    op;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [4:0]  rd;
    logic [31:0] rdata;
    int          gnt_dly;
    logic        rsp_err;
    logic        misal;
    logic [31:0] exp_daddr;
    logic [3:0]  exp_be;
    logic [31:0] exp_dwdata;
    logic        exp_wb;
    logic [31:0] exp_wbdata;
  } vec_t;

  typedef struct {
    logic        err;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } rsp_t;

  rsp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Response monitor: every we_o or lsu_err_o pulse must match the oldest
  // outstanding expectation.
  always @(posedge clk) begin
    #1;
    if (we || lsu_err) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_rsp", {30'h0, we, lsu_err}, 32'h0);
      end else begin
        rsp_t e;
        e = sb_q.pop_front();
        chk("rsp_err", {31'h0, lsu_err}, {31'h0, e.err});
        chk("rsp_we", {31'h0, we}, {31'h0, !e.err});
        if (!e.err) begin
          chk("rsp_waddr", {27'h0, waddr}, {27'h0, e.waddr});
          chk("rsp_wdata", wdata, e.wdata);
        end
      end
    end
  end

  task automatic run_vec(input vec_t v);
    int   guard;
    logic is_st;
    rsp_t r;
    is_st = (v.op == LSU_SB) || (v.op == LSU_SH) || (v.op == LSU_SW);
    guard = 0;
    while (lsu_busy && guard < 20) begin
      @(posedge clk); #1; guard++;
    end
    chk("idle_before_req", {31'h0, lsu_busy}, 32'h0);
    lsu_req = 1'b1; lsu_we = is_st; lsu_op = v.op;
    lsu_addr = v.addr; lsu_wdata = v.wd; rd_addr = v.rd;
    if (v.misal || v.rsp_err) begin
      r.err = 1'b1; r.waddr = 5'd0; r.wdata = 32'h0; sb_q.push_back(r);
    end else if (v.exp_wb) begin
      r.err = 1'b0; r.waddr = v.rd; r.wdata = v.exp_wbdata; sb_q.push_back(r);
    end
    @(posedge clk); #1;
    lsu_req = 1'b0;
    if (v.misal) begin
      chk("misal_err", {31'h0, lsu_err}, 32'h1);
      chk("misal_req", {31'h0, data_req}, 32'h0);
      chk("misal_busy", {31'h0, lsu_busy}, 32'h0);
      @(posedge clk); #1;
      chk("misal_err_clear", {31'h0, lsu_err}, 32'h0);
      return;
    end
    chk("req_busy", {31'h0, lsu_busy}, 32'h1);
    chk("req_req", {31'h0, data_req}, 32'h1);
    chk("req_addr", data_addr, v.exp_daddr);
    chk("req_be", {28'h0, data_be}, {28'h0, v.exp_be});
    chk("req_we", {31'h0, data_we}, {31'h0, is_st});
    if (is_st) chk("req_wdata", data_wdata, v.exp_dwdata);
    for (int i = 0; i < v.gnt_dly; i++) begin
      @(posedge clk); #1;
      chk("stall_req", {31'h0, data_req}, 32'h1);
      chk("stall_addr", data_addr, v.exp_daddr);
      chk("stall_be", {28'h0, data_be}, {28'h0, v.exp_be});
      if (is_st) chk("stall_wdata", data_wdata, v.exp_dwdata);
    end
    data_gnt = 1'b1;
    @(posedge clk); #1;
    data_gnt = 1'b0;
    chk("wait_req_low", {31'h0, data_req}, 32'h0);
    chk("wait_busy", {31'h0, lsu_busy}, 32'h1);
    data_rvalid = 1'b1; data_rdata = v.rdata; data_err = v.rsp_err;
    @(posedge clk); #1;
    data_rvalid = 1'b0; data_err = 1'b0; data_rdata = 32'h0;
    chk("done_busy", {31'h0, lsu_busy}, 32'h0);
  endtask

  vec_t vecs[$];

  task automatic add(input lsu_opt_e op, input logic [31:0] a, input logic [31:0] wd,
                     input logic [4:0] rd, input logic [31:0] rdata, input int dly,
                     input logic rerr, input logic mis, input logic [31:0] da,
                     input logic [3:0] be, input logic [31:0] dwd, input logic wb,
                     input logic [31:0] wbd);
    vec_t v;
    v.op = op; v.addr = a; v.wd = wd; v.rd = rd; v.rdata = rdata; v.gnt_dly = dly;
    v.rsp_err = rerr; v.misal = mis; v.exp_daddr = da; v.exp_be = be;
    v.exp_dwdata = dwd; v.exp_wb = wb; v.exp_wbdata = wbd;
    vecs.push_back(v);
  endtask

  initial begin
    rst_n = 1'b0; lsu_req = 1'b0; lsu_we = 1'b0; lsu_op = LSU_LB;
    lsu_addr = 32'h0; lsu_wdata = 32'h0; rd_addr = 5'd0;
    data_gnt = 1'b0; data_rvalid = 1'b0; data_err = 1'b0; data_rdata = 32'h0;

    //  op      addr         wdata         rd  rdata        dly err mis daddr        be       dwdata        wb  wbdata
    add(LSU_SW,  32'h100, 32'hDEADBEEF, 5'd0,  32'h0,        0, 0, 0, 32'h100, 4'b1111, 32'hDEADBEEF, 0, 32'h0);
    add(LSU_LB,  32'h203, 32'h0,        5'd5,  32'h80FF0000, 0, 0, 0, 32'h200, 4'b1111, 32'h0,        1, 32'hFFFFFF80);
    add(LSU_LBU, 32'h203, 32'h0,        5'd6,  32'h80FF0000, 0, 0, 0, 32'h200, 4'b1111, 32'h0,        1, 32'h00000080);
    add(LSU_SH,  32'h302, 32'h0000ABCD, 5'd0,  32'h0,        3, 0, 0, 32'h300, 4'b1100, 32'hABCDABCD, 0, 32'h0);
    add(LSU_LW,  32'h101, 32'h0,        5'd4,  32'h0,        0, 0, 1, 32'h0,   4'b0000, 32'h0,        0, 32'h0);
    add(LSU_LH,  32'h400, 32'h0,        5'd7,  32'h12345678, 0, 1, 0, 32'h400, 4'b1111, 32'h0,        0, 32'h0);
    add(LSU_LW,  32'h500, 32'h0,        5'd0,  32'h12345678, 0, 0, 0, 32'h500, 4'b1111, 32'h0,        0, 32'h0);
    add(LSU_SB,  32'h601, 32'h123456A5, 5'd0,  32'h0,        1, 0, 0, 32'h600, 4'b0010, 32'hA5A5A5A5, 0, 32'h0);
    add(LSU_LHU, 32'h702, 32'h0,        5'd9,  32'hBEEF1234, 0, 0, 0, 32'h700, 4'b1111, 32'h0,        1, 32'h0000BEEF);
    add(LSU_LH,  32'h702, 32'h0,        5'd10, 32'hBEEF1234, 0, 0, 0, 32'h700, 4'b1111, 32'h0,        1, 32'hFFFFBEEF);
    add(LSU_LW,  32'h800, 32'h0,        5'd31, 32'hCAFEF00D, 1, 0, 0, 32'h800, 4'b1111, 32'h0,        1, 32'hCAFEF00D);
    add(LSU_SH,  32'h301, 32'h0,        5'd0,  32'h0,        0, 0, 1, 32'h0,   4'b0000, 32'h0,        0, 32'h0);
    add(LSU_LB,  32'h000, 32'h0,        5'd1,  32'h0000007F, 0, 0, 0, 32'h000, 4'b1111, 32'h0,        1, 32'h0000007F);
    add(LSU_SB,  32'h003, 32'h000000C3, 5'd0,  32'h0,        0, 0, 0, 32'h000, 4'b1000, 32'hC3C3C3C3, 0, 32'h0);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'h0, lsu_busy}, 32'h0);
    chk("rst_req", {31'h0, data_req}, 32'h0);
    chk("rst_be", {28'h0, data_be}, 32'h0);
    chk("rst_we_o", {31'h0, we}, 32'h0);
    chk("rst_err", {31'h0, lsu_err}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset while waiting for the response aborts the access.
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_op = LSU_LW; lsu_addr = 32'h900; rd_addr = 5'd3;
    @(posedge clk); #1;
    lsu_req = 1'b0; data_gnt = 1'b1;
    @(posedge clk); #1;
    data_gnt = 1'b0;
    chk("abort_wait_busy", {31'h0, lsu_busy}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'h0, lsu_busy}, 32'h0);
    chk("abort_req", {31'h0, data_req}, 32'h0);
    chk("abort_addr", data_addr, 32'h0);
    chk("abort_be", {28'h0, data_be}, 32'h0);
    chk("abort_we_o", {31'h0, we}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    data_rvalid = 1'b1; data_rdata = 32'h55AA55AA;
    @(posedge clk); #1;
    data_rvalid = 1'b0; data_rdata = 32'h0;
    chk("stray_rvalid_we_o", {31'h0, we}, 32'h0);
    chk("stray_rvalid_busy", {31'h0, lsu_busy}, 32'h0);
    begin
      vec_t v;
      v.op = LSU_LW; v.addr = 32'h904; v.wd = 32'h0; v.rd = 5'd3; v.rdata = 32'h0BADF00D;
      v.gnt_dly = 0; v.rsp_err = 1'b0; v.misal = 1'b0; v.exp_daddr = 32'h904;
      v.exp_be = 4'b1111; v.exp_dwdata = 32'h0; v.exp_wb = 1'b1; v.exp_wbdata = 32'h0BADF00D;
      run_vec(v);
    end

    @(posedge clk); #2;
    chk("sb_drained", sb_q.size(), 32'h0);
    chk("final_we_o", {31'h0, we}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lsu_mem_if.md
Name: lsu_mem_if

Overview:
- Load/store unit in the milano EX stage. Consumes the LSU command stream registered by the ID-EX pipeline register: lsu_req, lsu_we and lsu_operate, plus the EX-computed address, store data and rd.
- Drives the data-memory req/gnt/rvalid handshake and aligns byte/half/word accesses.
- Produces the register-file write port (we/waddr/wdata) that feeds back into the ID stage for loads.

Parameters:
- ADDR_W, 32, data-memory address width; lsu_addr_i is truncated to this width onto data_addr_o.
- MISALIGN_CHECK, 1, 1 = misaligned half/word accesses raise lsu_err_o with no bus request; 0 = forwarded with the low address bits cleared.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- lsu_req_i  in  1  access command valid from ID-EX
- lsu_we_i  in  1  1 = store, 0 = load
- lsu_operate_i  in  milano_pkg::lsu_opt_e  LSU_LB/LH/LW/LBU/LHU/SB/SH/SW
- lsu_addr_i  in  32  effective address
- lsu_wdata_i  in  32  store data (rs2)
- rd_addr_i  in  5  load destination register
- lsu_busy_o  out  1  access in flight; upstream holds the next command
- lsu_err_o  out  1  one-cycle pulse on misalign or bus error
- data_req_o  out  1  memory request
- data_gnt_i  in  1  memory grant
- data_rvalid_i  in  1  response valid
- data_err_i  in  1  response error, qualified by rvalid
- data_addr_o  out  ADDR_W  word-aligned address
- data_we_o  out  1  write enable
- data_be_o  out  4  byte enables
- data_wdata_o  out  32  lane-aligned store data
- data_rdata_i  in  32  load data
- we_o  out  1  register-file write enable
- waddr_o  out  5  register-file write address
- wdata_o  out  32  register-file write data

Behaviour:
- Reset values: all outputs 0, FSM in IDLE. Reset mid-access aborts the access. A data_rvalid_i arriving after reset is ignored.
- FSM states: IDLE, REQ, WAIT_RSP.
  - lsu_busy_o = (state != IDLE), combinational from state.
- IDLE:
  - lsu_req_i=1 accepts the command in that cycle and latches operate, we, addr, wdata and rd.
  - If MISALIGN_CHECK=1 and the access is misaligned (H with addr[0]=1, W with addr[1:0]!=0): pulse lsu_err_o next cycle and stay in IDLE. No memory request, no writeback.
  - Otherwise go to REQ.
- REQ:
  - data_req_o=1 with addr/we/be/wdata held stable until data_gnt_i=1.
  - On gnt go to WAIT_RSP; data_req_o is 0 from the next cycle.
  - gnt may be held low indefinitely.
- WAIT_RSP:
  - Wait for data_rvalid_i; it is earliest the cycle after gnt.
  - On rvalid return to IDLE next cycle.
  - Load without error: we_o=1 for exactly one cycle (the cycle after rvalid), with waddr_o=rd and wdata_o=extracted data.
  - Store: no writeback.
  - data_err_i=1 with rvalid: lsu_err_o pulses one cycle and we_o stays 0.
- Writeback to x0: we_o is suppressed when rd=0.
- Back-to-back: a new lsu_req_i is accepted in the same cycle we_o pulses (state is IDLE then).
- lsu_req_i while busy: ignored, not queued; upstream must stall on lsu_busy_o.
- Address: data_addr_o = {addr[ADDR_W-1:2], 2'b00}.
- Stores:
  - SB: be = 4'b0001 << addr[1:0]; wdata = byte replicated x4.
  - SH: be = addr[1] ? 4'b1100 : 4'b0011; wdata = half replicated x2.
  - SW: be = 4'b1111; wdata unchanged.
- Loads:
  - shifted = rdata >> (8*addr[1:0]).
  - LB/LH sign-extend bit 7/15 of shifted; LBU/LHU zero-extend; LW passes rdata unchanged.
  - Loads drive be = 4'b1111.

Test Plan:
- SW addr=0x100, wdata=0xDEADBEEF, gnt same cycle as req, rvalid next -> data_be_o=1111, data_addr_o=0x100, data_we_o=1; no we_o; busy for 2 cycles after acceptance.
- LB addr=0x203, rdata=0x80FF_0000, rd=5 -> data_addr_o=0x200; we_o=1, waddr_o=5, wdata_o=0xFFFFFF80, one cycle after rvalid; LBU same -> 0x00000080.
- SH addr=0x302, wdata=0x0000ABCD, gnt delayed 3 cycles -> data_req_o high 4 cycles with stable addr 0x300, be=1100, wdata=0xABCDABCD.
- LW addr=0x101 with MISALIGN_CHECK=1 -> no data_req_o, lsu_err_o pulse one cycle after acceptance, busy stays 0, no we_o.
- LH addr=0x400 with rvalid + data_err_i=1 -> lsu_err_o pulse, we_o=0; LW with rd=0 -> we_o=0.
- rst_ni low while in WAIT_RSP -> outputs 0 immediately; subsequent stray rvalid produces no we_o; next LW completes normally.
